// File: rtl/pll_reset_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : pll_reset_seq                                                |
// | Description : Staged reset sequencer driven by PLL lock. Waits for a       |
// |               qualified lock, releases the core reset, and releases the io |
// |               reset STAGE_GAP cycles later. It counts lock losses that     |
// |               occur after release has started.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_reset_seq #(
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       rst_core,
  output logic       rst_io,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    REL_CORE  = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counter values. The counter starts at zero on entry to each timed
  // state, so the last qualifying cycle is at count N-1.
  localparam logic [15:0] c_LOCK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] c_GAP_LAST  = 16'(STAGE_GAP - 1);

  logic        r_sync1;
  logic        r_locked_s;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_rst_core;
  logic        r_rst_io;
  logic        r_ready;
  logic [7:0]  r_loss_cnt;
  logic        w_loss_sat;

  assign w_loss_sat = (r_loss_cnt == 8'hFF);

  // Bring the asynchronous lock indication into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= locked;
      r_locked_s <= r_sync1;
    end
  end

  // Sequencer FSM. Outputs are registered and updated on the same edge as
  // the transition, so they always agree with the state register.
  // A loss of lock has priority over every timed transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= 16'd0;
      r_rst_core <= 1'b1;
      r_rst_io   <= 1'b1;
      r_ready    <= 1'b0;
      r_loss_cnt <= 8'd0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (r_locked_s) begin
            r_state <= STABLE;
            r_cnt   <= 16'd0;
          end
        end
        STABLE: begin
          if (!r_locked_s) begin
            // Glitch during qualification: restart without counting a loss.
            r_state <= WAIT_LOCK;
            r_cnt   <= 16'd0;
          end else if (r_cnt == c_LOCK_LAST) begin
            r_state    <= REL_CORE;
            r_cnt      <= 16'd0;
            r_rst_core <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        REL_CORE: begin
          if (!r_locked_s) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= 16'd0;
            r_rst_core <= 1'b1;
            r_rst_io   <= 1'b1;
            r_ready    <= 1'b0;
            if (!w_loss_sat) r_loss_cnt <= r_loss_cnt + 8'd1;
          end else if (r_cnt == c_GAP_LAST) begin
            r_state  <= RUN;
            r_cnt    <= 16'd0;
            r_rst_io <= 1'b0;
            r_ready  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!r_locked_s) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= 16'd0;
            r_rst_core <= 1'b1;
            r_rst_io   <= 1'b1;
            r_ready    <= 1'b0;
            if (!w_loss_sat) r_loss_cnt <= r_loss_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign rst_core        = r_rst_core;
  assign rst_io          = r_rst_io;
  assign ready           = r_ready;
  assign lock_loss_count = r_loss_cnt;
  assign state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_pll_reset_seq                                             |
// | Description : Scoreboard bench for pll_reset_seq with a behavioural model  |
// |               based on the length of the current synchronized-lock run.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pll_reset_seq;

  localparam int L = 16;
  localparam int G = 8;

  typedef struct packed {
    logic       core;
    logic       io;
    logic       rdy;
    logic [7:0] llc;
    logic [1:0] st;
  } obs_t;

  localparam obs_t c_RESET_OBS = '{core: 1'b1, io: 1'b1, rdy: 1'b0, llc: 8'd0, st: 2'd0};

  logic       clk;
  logic       reset, locked;
  logic       rst_core, rst_io, ready;
  logic [7:0] lock_loss_count;
  logic [1:0] state;

  logic       reset1, locked1;
  logic       rst_core1, rst_io1, ready1;
  logic [7:0] lock_loss_count1;
  logic [1:0] state1;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t exp_q[$];

  // Model state: sync pipeline, length of the current run of
  // synchronized-lock samples seen by the FSM, and loss count.
  logic m_s1, m_s2;
  int   m_k;
  int   m_llc;

  pll_reset_seq #(.LOCK_CYCLES(L), .STAGE_GAP(G)) u_dut (
    .clk(clk), .reset(reset), .locked(locked),
    .rst_core(rst_core), .rst_io(rst_io), .ready(ready),
    .lock_loss_count(lock_loss_count), .state(state)
  );

  pll_reset_seq #(.LOCK_CYCLES(1), .STAGE_GAP(1)) u_dut_min (
    .clk(clk), .reset(reset1), .locked(locked1),
    .rst_core(rst_core1), .rst_io(rst_io1), .ready(ready1),
    .lock_loss_count(lock_loss_count1), .state(state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: actual core=%0b io=%0b ready=%0b loss=%0d state=%0d, required core=%0b io=%0b ready=%0b loss=%0d state=%0d",
                  name, $time, act.core, act.io, act.rdy, act.llc, act.st,
                  exp.core, exp.io, exp.rdy, exp.llc, exp.st);
  endtask

  function automatic obs_t obs_main();
    return {rst_core, rst_io, ready, lock_loss_count, state};
  endfunction

  function automatic obs_t obs_min();
    return {rst_core1, rst_io1, ready1, lock_loss_count1, state1};
  endfunction

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_k = 0; m_llc = 0;
  endtask

  // Expected outputs from the run length: k=0 waiting, 1..L qualifying,
  // L+1..L+G core released, beyond that fully running.
  function automatic obs_t model_obs();
    obs_t o;
    o.core = (m_k <= L);
    o.io   = (m_k <= L + G);
    o.rdy  = (m_k > L + G);
    o.llc  = 8'(m_llc);
    o.st   = (m_k == 0) ? 2'd0 : (m_k <= L) ? 2'd1 : (m_k <= L + G) ? 2'd2 : 2'd3;
    return o;
  endfunction

  // Advance the model by one clock edge given the inputs at that edge.
  task automatic model_step(input logic lk, input logic rs);
    logic seen;
    if (rs) begin
      model_reset();
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      if (seen) begin
        if (m_k < L + G + 1) m_k++;
      end else begin
        if (m_k >= L + 1 && m_llc < 255) m_llc++;
        m_k = 0;
      end
    end
  endtask

  // Drive inputs for the next rising edge and queue the expected result.
  task automatic drive(input logic lk, input logic rs);
    @(negedge clk);
    locked = lk;
    reset  = rs;
    model_step(lk, rs);
    exp_q.push_back(model_obs());
  endtask

  task automatic drive_n(input int n, input logic lk, input logic rs);
    for (int i = 0; i < n; i++) drive(lk, rs);
  endtask

  // Monitor: one observation per clock edge, compared in order.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", obs_main(), e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, actual time %0t required < 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t e1;
    locked = 1'b0; reset = 1'b1;
    locked1 = 1'b0; reset1 = 1'b1;
    model_reset();

    // Minimum-parameter instance: release from edge 1 sampling locked=1.
    repeat (2) @(negedge clk);
    check("min_reset", obs_min(), c_RESET_OBS);
    reset1 = 1'b0; locked1 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #2;
      e1.core = (e < 4);
      e1.io   = (e < 5);
      e1.rdy  = (e >= 5);
      e1.llc  = 8'd0;
      e1.st   = (e <= 2) ? 2'd0 : (e == 3) ? 2'd1 : (e == 4) ? 2'd2 : 2'd3;
      check($sformatf("min_edge%0d", e), obs_min(), e1);
    end

    // Reset values, then steady lock from power-up.
    drive_n(3, 1'b0, 1'b1);
    drive_n(30, 1'b1, 1'b0);

    // Short glitch during qualification.
    drive_n(2, 1'b0, 1'b1);
    drive_n(10, 1'b1, 1'b0);
    drive_n(3, 1'b0, 1'b0);
    drive_n(30, 1'b1, 1'b0);

    // Randomized lock runs with occasional resets.
    for (int r = 0; r < 40; r++) begin
      drive_n($urandom_range(40, 1), 1'b1, 1'b0);
      drive_n($urandom_range(4, 1), 1'b0, 1'b0);
      if ($urandom_range(9, 0) == 0) drive_n($urandom_range(2, 1), $urandom_range(1, 0) == 1, 1'b1);
    end

    // Asynchronous reset while running.
    drive_n(30, 1'b1, 1'b0);
    drive(1'b1, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", obs_main(), c_RESET_OBS);
    model_reset();
    drive_n(2, 1'b1, 1'b1);
    drive_n(30, 1'b1, 1'b0);

    // Push the loss counter past saturation.
    for (int r = 0; r < 260; r++) begin
      drive_n(20, 1'b1, 1'b0);
      drive(1'b0, 1'b0);
    end
    drive_n(4, 1'b0, 1'b0);
    drive_n(30, 1'b1, 1'b0);
    drive_n(4, 1'b0, 1'b0);

    // Let the monitor drain the queue.
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: actual %0d queued entries, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
